axi_sram_slave: RTL and testbench



---
 rtl/axi_sram_slave.sv | 200 ++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI4 slave around a byte-writable single-port-per-channel SRAM
module axi_sram_slave #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 16,
  parameter int ID_W   = 4,
  parameter int DEPTH  = 256
) (
  input  logic                  i_aclk,
  input  logic                  i_areset,
  input  logic [ID_W-1:0]       i_arid,
  input  logic [ADDR_W-1:0]     i_araddr,
  input  logic [7:0]            i_arlen,
  input  logic [2:0]            i_arsize,
  input  logic [1:0]            i_arburst,
  input  logic                  i_arvalid,
  output logic                  o_arready,
  output logic [ID_W-1:0]       o_rid,
  output logic [DATA_W-1:0]     o_rdata,
  output logic [1:0]            o_rresp,
  output logic                  o_rlast,
  output logic                  o_rvalid,
  input  logic                  i_rready,
  input  logic [ID_W-1:0]       i_awid,
  input  logic [ADDR_W-1:0]     i_awaddr,
  input  logic [7:0]            i_awlen,
  input  logic [2:0]            i_awsize,
  input  logic [1:0]            i_awburst,
  input  logic                  i_awvalid,
  output logic                  o_awready,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [DATA_W/8-1:0]   i_wstrb,
  input  logic                  i_wlast,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  output logic [ID_W-1:0]       o_bid,
  output logic [1:0]            o_bresp,
  output logic                  o_bvalid,
  input  logic                  i_bready
);
  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam logic [ADDR_W:0] MEM_TOP = (ADDR_W+1)'(DEPTH * STRB_W);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic [7:0] len,
                                                  input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_W-1:0] step, incr, wmask;
    step  = ADDR_W'(1) << size;
    incr  = (a & ~(step - ADDR_W'(1))) + step;
    wmask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    case (burst)
      2'b01:   next_addr = incr;
      2'b10:   next_addr = (a & ~wmask) | (incr & wmask);
      default: next_addr = a;
    endcase
  endfunction

  function automatic logic burst_err(input logic [2:0] size, input logic [7:0] len, input logic [1:0] burst);
    burst_err = (size > 3'(LSB)) ||
                ((burst == 2'b10) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
  endfunction

  function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
    out_of_range = {1'b0, a} >= MEM_TOP;
  endfunction

  r_state_t r_state_q, r_state_d;
  logic [ID_W-1:0] r_id_q, r_id_d;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d;
  logic [7:0] r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [2:0] r_size_q, r_size_d;
  logic [1:0] r_burst_q, r_burst_d, r_resp_q;
  logic r_berr_q, r_berr_d;
  logic [DATA_W-1:0] r_data_q;
  logic rd_fetch, rd_fetch_err;
  logic [IDX_W-1:0] rd_fetch_idx;

  w_state_t w_state_q, w_state_d;
  logic [ID_W-1:0] w_id_q, w_id_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [7:0] w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [2:0] w_size_q, w_size_d;
  logic [1:0] w_burst_q, w_burst_d, w_bresp_q, w_bresp_d;
  logic w_berr_q, w_berr_d, w_err_q, w_err_d;
  logic wr_en, w_beat_err, w_beat_last;

  assign o_arready = (r_state_q == R_IDLE) && !i_areset;
  assign o_rvalid  = (r_state_q == R_DATA);
  assign o_rlast   = o_rvalid && (r_cnt_q == r_len_q);
  assign o_rid     = r_id_q;
  assign o_rdata   = r_data_q;
  assign o_rresp   = r_resp_q;
  assign o_awready = (w_state_q == W_IDLE) && !i_areset;
  assign o_wready  = (w_state_q == W_DATA);
  assign o_bvalid  = (w_state_q == W_RESP);
  assign o_bid     = w_id_q;
  assign o_bresp   = w_bresp_q;

  // Read channel next state: latch AR payload, step the address and request a word fetch per beat
  always_comb begin
    r_state_d = r_state_q; r_id_d = r_id_q; r_addr_d = r_addr_q; r_len_d = r_len_q;
    r_size_d = r_size_q; r_burst_d = r_burst_q; r_cnt_d = r_cnt_q; r_berr_d = r_berr_q;
    rd_fetch = 1'b0; rd_fetch_err = 1'b0; rd_fetch_idx = '0;
    case (r_state_q)
      R_IDLE: if (o_arready && i_arvalid) begin
        r_state_d = R_DATA; r_id_d = i_arid; r_addr_d = i_araddr; r_len_d = i_arlen;
        r_size_d = i_arsize; r_burst_d = i_arburst; r_cnt_d = 8'd0;
        r_berr_d = burst_err(i_arsize, i_arlen, i_arburst);
        rd_fetch = 1'b1;
        rd_fetch_idx = i_araddr[LSB +: IDX_W];
        rd_fetch_err = r_berr_d || out_of_range(i_araddr);
      end
      R_DATA: if (i_rready) begin
        if (r_cnt_q == r_len_q) begin
          r_state_d = R_IDLE;
        end else begin
          r_cnt_d = r_cnt_q + 8'd1;
          r_addr_d = next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
          rd_fetch = 1'b1;
          rd_fetch_idx = r_addr_d[LSB +: IDX_W];
          rd_fetch_err = r_berr_q || out_of_range(r_addr_d);
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write channel next state: commit strobed beats, accumulate errors, then hold the B response
  always_comb begin
    w_state_d = w_state_q; w_id_d = w_id_q; w_addr_d = w_addr_q; w_len_d = w_len_q;
    w_size_d = w_size_q; w_burst_d = w_burst_q; w_cnt_d = w_cnt_q; w_berr_d = w_berr_q;
    w_err_d = w_err_q; w_bresp_d = w_bresp_q;
    w_beat_last = (w_cnt_q == w_len_q);
    w_beat_err = w_berr_q || out_of_range(w_addr_q);
    wr_en = 1'b0;
    case (w_state_q)
      W_IDLE: if (o_awready && i_awvalid) begin
        w_state_d = W_DATA; w_id_d = i_awid; w_addr_d = i_awaddr; w_len_d = i_awlen;
        w_size_d = i_awsize; w_burst_d = i_awburst; w_cnt_d = 8'd0; w_err_d = 1'b0;
        w_berr_d = burst_err(i_awsize, i_awlen, i_awburst);
      end
      W_DATA: if (i_wvalid && !i_areset) begin
        wr_en = !w_beat_err;
        w_err_d = w_err_q || w_beat_err || (i_wlast != w_beat_last);
        if (w_beat_last) begin
          w_state_d = W_RESP;
          w_bresp_d = w_err_d ? SLVERR : OKAY;
        end else begin
          w_cnt_d = w_cnt_q + 8'd1;
          w_addr_d = next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
        end
      end
      W_RESP: if (i_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // State and burst-context registers for both channels
  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      r_state_q <= R_IDLE; r_id_q <= '0; r_addr_q <= '0; r_len_q <= '0; r_size_q <= '0;
      r_burst_q <= '0; r_cnt_q <= '0; r_berr_q <= 1'b0;
      w_state_q <= W_IDLE; w_id_q <= '0; w_addr_q <= '0; w_len_q <= '0; w_size_q <= '0;
      w_burst_q <= '0; w_cnt_q <= '0; w_berr_q <= 1'b0; w_err_q <= 1'b0; w_bresp_q <= OKAY;
    end else begin
      r_state_q <= r_state_d; r_id_q <= r_id_d; r_addr_q <= r_addr_d; r_len_q <= r_len_d;
      r_size_q <= r_size_d; r_burst_q <= r_burst_d; r_cnt_q <= r_cnt_d; r_berr_q <= r_berr_d;
      w_state_q <= w_state_d; w_id_q <= w_id_d; w_addr_q <= w_addr_d; w_len_q <= w_len_d;
      w_size_q <= w_size_d; w_burst_q <= w_burst_d; w_cnt_q <= w_cnt_d; w_berr_q <= w_berr_d;
      w_err_q <= w_err_d; w_bresp_q <= w_bresp_d;
    end
  end

  // Byte-lane writes; contents survive reset
  always_ff @(posedge i_aclk) begin
    if (wr_en) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (i_wstrb[k]) mem[w_addr_q[LSB +: IDX_W]][8*k +: 8] <= i_wdata[8*k +: 8];
      end
    end
  end

  // Registered read port; sees pre-write contents on a same-cycle collision, holds while stalled
  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      r_data_q <= '0;
      r_resp_q <= OKAY;
    end else if (rd_fetch) begin
      r_data_q <= rd_fetch_err ? '0 : mem[rd_fetch_idx];
      r_resp_q <= rd_fetch_err ? SLVERR : OKAY;
    end
  end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - scoreboard bench for axi_sram_slave
module tb_axi_sram_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] arid = '0, awid = '0, rid, bid;
  logic [15:0] araddr = '0, awaddr = '0;
  logic [7:0] arlen = '0, awlen = '0, wstrb = '0;
  logic [2:0] arsize = '0, awsize = '0;
  logic [1:0] arburst = '0, awburst = '0, rresp, bresp;
  logic arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, rready = 1'b0, bready = 1'b1;
  logic arready, awready, wready, rvalid, rlast, bvalid;
  logic [63:0] rdata, wdata = '0;

  axi_sram_slave #(.DATA_W(64), .ADDR_W(16), .ID_W(4), .DEPTH(256)) dut (
    .i_aclk(clk), .i_areset(rst),
    .i_arid(arid), .i_araddr(araddr), .i_arlen(arlen), .i_arsize(arsize), .i_arburst(arburst),
    .i_arvalid(arvalid), .o_arready(arready),
    .o_rid(rid), .o_rdata(rdata), .o_rresp(rresp), .o_rlast(rlast), .o_rvalid(rvalid), .i_rready(rready),
    .i_awid(awid), .i_awaddr(awaddr), .i_awlen(awlen), .i_awsize(awsize), .i_awburst(awburst),
    .i_awvalid(awvalid), .o_awready(awready),
    .i_wdata(wdata), .i_wstrb(wstrb), .i_wlast(wlast), .i_wvalid(wvalid), .o_wready(wready),
    .o_bid(bid), .o_bresp(bresp), .o_bvalid(bvalid), .i_bready(bready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rbeat_t;

  rbeat_t rexp[$];
  logic [5:0] bexp[$];
  int n_tests = 0;
  int n_fail = 0;
  int r_seen = 0;
  int b_seen = 0;
  bit after_last = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_r(input logic [63:0] d, input logic [1:0] resp, input logic last, input logic [3:0] id);
    rbeat_t b;
    b.data = d; b.resp = resp; b.last = last; b.id = id;
    rexp.push_back(b);
  endtask

  // R monitor: every valid cycle is compared with the head beat; a handshake retires it
  always @(negedge clk) begin
    if (after_last) begin
      check("r_after_last_rvalid", 128'(rvalid), 128'(0));
      check("r_after_last_arready", 128'(arready), 128'(1));
      after_last = 1'b0;
    end
    if (rvalid) begin
      check("r_busy_arready", 128'(arready), 128'(0));
      if (rexp.size() == 0) begin
        check("r_unexpected_beat", 128'(1), 128'(0));
      end else begin
        check(rready ? "r_data" : "r_hold_data", 128'(rdata), 128'(rexp[0].data));
        check(rready ? "r_resp" : "r_hold_resp", 128'(rresp), 128'(rexp[0].resp));
        check(rready ? "r_last" : "r_hold_last", 128'(rlast), 128'(rexp[0].last));
        check("r_id", 128'(rid), 128'(rexp[0].id));
        if (rready) begin
          if (rexp[0].last) after_last = 1'b1;
          void'(rexp.pop_front());
          r_seen++;
        end
      end
    end
  end

  // B monitor
  always @(negedge clk) begin
    if (bvalid && bready) begin
      if (bexp.size() == 0) begin
        check("b_unexpected", 128'(1), 128'(0));
      end else begin
        check("b_id", 128'(bid), 128'(bexp[0][5:2]));
        check("b_resp", 128'(bresp), 128'(bexp[0][1:0]));
        void'(bexp.pop_front());
      end
      b_seen++;
    end
  end

  task automatic do_write(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [63:0] base, input logic [7:0] strb,
                          input int last_beat, input logic [1:0] exp_resp);
    int n;
    int tgt;
    bexp.push_back({id, exp_resp});
    tgt = b_seen + 1;
    @(posedge clk); #1;
    awid = id; awaddr = addr; awlen = len; awsize = 3'd3; awburst = burst; awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!awready && n < 100) begin @(negedge clk); n++; end
    check("aw_ready", 128'(awready), 128'(1));
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = base + 64'(i); wstrb = strb; wlast = (i == last_beat); wvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!wready && n < 100) begin @(negedge clk); n++; end
      check("w_ready", 128'(wready), 128'(1));
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    @(negedge clk);
    check("w_done_wready", 128'(wready), 128'(0));
    check("w_done_bvalid", 128'(bvalid), 128'(1));
    n = 0;
    while (b_seen < tgt && n < 50) begin @(posedge clk); n++; end
    check("b_count", 128'(b_seen), 128'(tgt));
  endtask

  task automatic do_read(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input bit toggle);
    int n;
    int tgt;
    tgt = r_seen + int'(len) + 1;
    @(posedge clk); #1;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 100) begin @(negedge clk); n++; end
    check("ar_ready", 128'(arready), 128'(1));
    @(posedge clk); #1;
    arvalid = 1'b0;
    rready = 1'b1;
    n = 0;
    while (1) begin
      @(posedge clk); #1;
      n++;
      if (r_seen >= tgt || n >= 200) break;
      if (toggle) rready = !rready;
    end
    rready = 1'b0;
    check("r_count", 128'(r_seen), 128'(tgt));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_arready", 128'(arready), 128'(0));
    check("rst_awready", 128'(awready), 128'(0));
    check("rst_rvalid", 128'(rvalid), 128'(0));
    check("rst_wready", 128'(wready), 128'(0));
    check("rst_bvalid", 128'(bvalid), 128'(0));
    check("rst_rlast", 128'(rlast), 128'(0));
    check("rst_rdata", 128'(rdata), 128'(0));
    check("rst_rresp", 128'(rresp), 128'(0));
    check("rst_bresp", 128'(bresp), 128'(0));
    check("rst_rid", 128'(rid), 128'(0));
    check("rst_bid", 128'(bid), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rel_arready", 128'(arready), 128'(1));
    check("rel_awready", 128'(awready), 128'(1));

    // Seed words 0..7, then overwrite words 2..5 with 0xA0..0xA3
    do_write(4'd1, 16'h0000, 8'd7, 2'b01, 64'h100, 8'hFF, 7, 2'b00);
    do_write(4'd5, 16'h0010, 8'd3, 2'b01, 64'hA0, 8'hFF, 3, 2'b00);

    for (int i = 0; i < 4; i++) push_r(64'hA0 + 64'(i), 2'b00, i == 3, 4'd6);
    do_read(4'd6, 16'h0010, 8'd3, 3'd3, 2'b01, 1'b0);

    push_r(64'hA1, 2'b00, 1'b0, 4'd7);
    push_r(64'h100, 2'b00, 1'b0, 4'd7);
    push_r(64'h101, 2'b00, 1'b0, 4'd7);
    push_r(64'hA0, 2'b00, 1'b1, 4'd7);
    do_read(4'd7, 16'h0018, 8'd3, 3'd3, 2'b10, 1'b0);

    for (int i = 0; i < 3; i++) push_r(64'h0, 2'b10, i == 2, 4'd8);
    do_read(4'd8, 16'h0018, 8'd2, 3'd3, 2'b10, 1'b0);

    push_r(64'h0, 2'b10, 1'b1, 4'd1);
    do_read(4'd1, 16'h0000, 8'd0, 3'd4, 2'b01, 1'b0);

    do_write(4'd2, 16'h0040, 8'd0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 2'b00);
    do_write(4'd3, 16'h0040, 8'd0, 2'b01, 64'h0, 8'h0F, 0, 2'b00);
    push_r(64'hFFFF_FFFF_0000_0000, 2'b00, 1'b1, 4'd9);
    do_read(4'd9, 16'h0040, 8'd0, 3'd3, 2'b01, 1'b0);

    push_r(64'h100, 2'b00, 1'b0, 4'd10);
    push_r(64'h101, 2'b00, 1'b0, 4'd10);
    for (int i = 0; i < 4; i++) push_r(64'hA0 + 64'(i), 2'b00, 1'b0, 4'd10);
    push_r(64'h106, 2'b00, 1'b0, 4'd10);
    push_r(64'h107, 2'b00, 1'b1, 4'd10);
    do_read(4'd10, 16'h0000, 8'd7, 3'd3, 2'b01, 1'b1);

    do_write(4'd4, 16'h07F0, 8'd1, 2'b01, 64'hC0, 8'hFF, 1, 2'b00);
    push_r(64'hC0, 2'b00, 1'b0, 4'd11);
    push_r(64'hC1, 2'b00, 1'b0, 4'd11);
    push_r(64'h0, 2'b10, 1'b0, 4'd11);
    push_r(64'h0, 2'b10, 1'b1, 4'd11);
    do_read(4'd11, 16'h07F0, 8'd3, 3'd3, 2'b01, 1'b0);

    do_write(4'd6, 16'h0100, 8'd3, 2'b01, 64'hD0, 8'hFF, 1, 2'b10);
    do_write(4'd7, 16'h0800, 8'd0, 2'b01, 64'hDEAD, 8'hFF, 0, 2'b10);
    push_r(64'h100, 2'b00, 1'b1, 4'd12);
    do_read(4'd12, 16'h0000, 8'd0, 3'd3, 2'b01, 1'b0);

    push_r(64'h100, 2'b00, 1'b0, 4'd13);
    push_r(64'h101, 2'b00, 1'b0, 4'd13);
    push_r(64'hA0, 2'b00, 1'b0, 4'd13);
    push_r(64'hA1, 2'b00, 1'b1, 4'd13);
    fork
      do_write(4'd8, 16'h0200, 8'd3, 2'b01, 64'hE0, 8'hFF, 3, 2'b00);
      do_read(4'd13, 16'h0000, 8'd3, 3'd3, 2'b01, 1'b0);
    join
    for (int i = 0; i < 4; i++) push_r(64'hE0 + 64'(i), 2'b00, i == 3, 4'd14);
    do_read(4'd14, 16'h0200, 8'd3, 3'd3, 2'b01, 1'b0);

    // Reset in the middle of a stalled read burst
    push_r(64'h100, 2'b00, 1'b0, 4'd3);
    @(posedge clk); #1;
    arid = 4'd3; araddr = 16'h0000; arlen = 8'd7; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1;
    @(negedge clk);
    check("mid_ar_ready", 128'(arready), 128'(1));
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b0;
    @(negedge clk);
    check("mid_rvalid", 128'(rvalid), 128'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_rvalid", 128'(rvalid), 128'(0));
    check("mid_rst_wready", 128'(wready), 128'(0));
    check("mid_rst_bvalid", 128'(bvalid), 128'(0));
    check("mid_rst_arready", 128'(arready), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    rexp.delete();
    @(negedge clk);
    check("mid_rel_arready", 128'(arready), 128'(1));
    check("mid_rel_awready", 128'(awready), 128'(1));

    push_r(64'hA0, 2'b00, 1'b1, 4'd15);
    do_read(4'd15, 16'h0010, 8'd0, 3'd3, 2'b01, 1'b0);

    repeat (2) @(posedge clk);
    check("r_queue_empty", 128'(rexp.size()), 128'(0));
    check("b_queue_empty", 128'(bexp.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
